ram_program_loader: RTL and testbench

//  Sequences loading a program into the 16x8 RAM through the MAR and RAM write path, without front-panel switches.

---
 rtl/ram_program_loader.sv | 120 ++++++++++++
 tb/tb_ram_program_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_program_loader.sv
// Loads a program into RAM one byte at a time over valid/ready and holds the CPU for the whole load.
// Latency: byte accepted at N -> mar_load N+1 -> ram_write N+2 -> byte_ready again at N+3+SETTLE_CYCLES.
// Backpressure: byte_ready only in WAIT_BYTE, and abort removes it combinationally.
module ram_program_loader #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 27000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   prog_len,
  input  logic                  byte_valid,
  input  logic [DATA_WIDTH-1:0] byte_data,
  output logic                  byte_ready,
  output logic                  mar_load,
  output logic [ADDR_WIDTH-1:0] mar_addr,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [LW-1:0] DEPTH_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_SETADR = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  logic [2:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LW-1:0]         len;
  logic [LW-1:0]         len_clamped;
  logic [TW-1:0]         timeout;
  logic [SW-1:0]         settle_cnt;
  logic                  xfer, start_ok, timeout_hit, settle_last, last_addr;

  assign byte_ready  = (state == ST_WAIT) & ~abort;
  assign xfer        = byte_valid & byte_ready;
  assign start_ok    = start & ~abort & ((state == ST_IDLE) | (state == ST_ERROR));
  assign len_clamped = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
  assign timeout_hit = (timeout == TW'(TIMEOUT_CYCLES - 1));
  assign settle_last = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  // len is never 0 outside IDLE/DONE, so len-1 cannot underflow here
  assign last_addr   = ({1'b0, addr} == (len - LW'(1)));

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_ERROR: if (start) state_nxt = (len_clamped == '0) ? ST_DONE : ST_WAIT;
        ST_WAIT: begin
          if (xfer)             state_nxt = ST_SETADR;
          else if (timeout_hit) state_nxt = ST_ERROR;
        end
        ST_SETADR: state_nxt = ST_WRITE;
        ST_WRITE:  state_nxt = ST_SETTLE;
        ST_SETTLE: if (settle_last) state_nxt = last_addr ? ST_DONE : ST_WAIT;
        ST_DONE:   state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Strobes are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr       <= '0;
      len        <= '0;
      timeout    <= '0;
      settle_cnt <= '0;
      mar_load   <= 1'b0;
      mar_addr   <= '0;
      ram_write  <= 1'b0;
      ram_data   <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != ST_IDLE);
      cpu_hold  <= (state_nxt != ST_IDLE);
      mar_load  <= (state_nxt == ST_SETADR);
      ram_write <= (state_nxt == ST_WRITE);
      done      <= (state_nxt == ST_DONE);

      if (start_ok) begin
        len     <= len_clamped;
        addr    <= '0;
        timeout <= '0;
        error   <= 1'b0;
      end else if (state == ST_WAIT) begin
        timeout <= (xfer | timeout_hit) ? '0 : timeout + TW'(1);
        if (state_nxt == ST_ERROR) error <= 1'b1;
      end

      if (xfer) ram_data <= byte_data;
      if (state_nxt == ST_SETADR) mar_addr <= addr;

      if (state == ST_SETTLE) settle_cnt <= settle_last ? '0 : settle_cnt + SW'(1);
      else                    settle_cnt <= '0;

      if ((state == ST_SETTLE) && (state_nxt == ST_WAIT)) addr <= addr + ADDR_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_ram_program_loader.sv
// Directed bench for ram_program_loader: per-scenario tasks with inline expected-value checks.
module tb_ram_program_loader;
  logic       clk = 1'b0;
  logic       rst_n, start, abort, byte_valid;
  logic [4:0] prog_len;
  logic [7:0] byte_data;
  logic       byte_ready, mar_load, ram_write, cpu_hold, busy, done, error;
  logic [3:0] mar_addr;
  logic [7:0] ram_data;

  int errors = 0;
  int checks = 0;

  ram_program_loader #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .prog_len(prog_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mar_load(mar_load), .mar_addr(mar_addr), .ram_write(ram_write), .ram_data(ram_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Behavioural MAR + RAM fed by the loader, plus event counters
  logic [3:0] mar_q = 4'd0;
  logic [7:0] tb_ram [16];
  logic [3:0] wr_addr_q [$];
  int n_writes = 0;
  int n_done   = 0;

  initial for (int i = 0; i < 16; i++) tb_ram[i] = 8'h00;

  always @(posedge clk) begin
    if (mar_load) mar_q <= mar_addr;
    if (ram_write) begin
      tb_ram[mar_q] <= ram_data;
      wr_addr_q.push_back(mar_addr);
      n_writes = n_writes + 1;
    end
    if (done) n_done = n_done + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_writes = 0;
    n_done   = 0;
    wr_addr_q.delete();
  endtask

  task automatic do_start(input logic [4:0] len);
    start = 1'b1;
    prog_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 60; k++) begin
      if (byte_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    byte_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_byte: byte %h never accepted, required byte_ready within 60 cycles", b);
    end
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_wait_done: done=0 after 80 cycles, required done=1", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({byte_ready, mar_load, mar_addr, ram_write, ram_data, cpu_hold, busy, done, error} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {byte_ready, mar_load, mar_addr, ram_write, ram_data, cpu_hold, busy, done, error});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear_mon();
    do_start(5'd3);
    checks++;
    if (cpu_hold !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold: cpu_hold=%b busy=%b, required 1 1", cpu_hold, busy);
    end
    send_byte(8'h1E);
    send_byte(8'h2F);
    send_byte(8'hE0);
    wait_done("basic");
    tick();
    checks++;
    if (done !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: done=%b cpu_hold=%b busy=%b, required 0 0 0", done, cpu_hold, busy);
    end
    repeat (3) tick();
    checks++;
    if (tb_ram[0] !== 8'h1E || tb_ram[1] !== 8'h2F || tb_ram[2] !== 8'hE0) begin
      errors++;
      $display("FAIL basic_ram: got %h %h %h, required 1e 2f e0", tb_ram[0], tb_ram[1], tb_ram[2]);
    end
    checks++;
    if (wr_addr_q.size() != 3 || wr_addr_q[0] !== 4'd0 || wr_addr_q[1] !== 4'd1 || wr_addr_q[2] !== 4'd2) begin
      errors++;
      $display("FAIL basic_addr: %0d writes, required addresses 0,1,2", wr_addr_q.size());
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d, required 1", n_done);
    end
  endtask

  task automatic test_timing();
    int t0 = -1, t1 = -1, t2 = -1, t3 = -1;
    clear_mon();
    do_start(5'd2);
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    for (int k = 0; k < 20; k++) begin
      if (byte_ready && t0 < 0) t0 = k;
      else if (byte_ready && t3 < 0) t3 = k;
      if (mar_load && t1 < 0) t1 = k;
      if (ram_write && t2 < 0) t2 = k;
      tick();
    end
    byte_valid = 1'b0;
    checks++;
    if (t0 < 0 || t1 != t0 + 1 || t2 != t0 + 2 || t3 != t0 + 5) begin
      errors++;
      $display("FAIL timing: xfer=%0d mar_load=%0d ram_write=%0d next_xfer=%0d, required N,N+1,N+2,N+5", t0, t1, t2, t3);
    end
    checks++;
    if (n_writes != 2 || n_done != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timing_end: writes=%0d done=%0d busy=%b, required 2 1 0", n_writes, n_done, busy);
    end
  endtask

  task automatic test_long_and_empty();
    bit ok = 1'b1;
    clear_mon();
    do_start(5'd20);
    for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i));
    wait_done("long");
    repeat (2) tick();
    checks++;
    if (n_writes != 16 || n_done != 1) begin
      errors++;
      $display("FAIL long_count: writes=%0d done=%0d, required 16 1", n_writes, n_done);
    end
    if (wr_addr_q.size() != 16) ok = 1'b0;
    else for (int i = 0; i < 16; i++) if (wr_addr_q[i] !== 4'(i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL long_addr_seq: %0d writes out of order, required addresses 0..15", wr_addr_q.size());
    end
    checks++;
    if (mar_addr !== 4'd15 || tb_ram[15] !== 8'h4F || tb_ram[0] !== 8'h40) begin
      errors++;
      $display("FAIL long_final: mar_addr=%0d ram15=%h ram0=%h, required 15 4f 40", mar_addr, tb_ram[15], tb_ram[0]);
    end

    clear_mon();
    do_start(5'd0);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL empty_done: done=%b one cycle after start, required 1", done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || n_writes != 0) begin
      errors++;
      $display("FAIL empty_end: done=%b busy=%b writes=%0d, required 0 0 0", done, busy, n_writes);
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    clear_mon();
    do_start(5'd1);
    for (int k = 0; k < 20; k++) begin
      if (error) break;
      if (byte_ready) cnt++;
      tick();
    end
    checks++;
    if (cnt != 8 || error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_len: %0d wait cycles error=%b, required 8 1", cnt, error);
    end
    repeat (3) tick();
    checks++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || busy !== 1'b1 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: error=%b cpu_hold=%b busy=%b byte_ready=%b, required 1 1 1 0",
               error, cpu_hold, busy, byte_ready);
    end
    do_start(5'd1);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: error=%b after start, required 0", error);
    end
    send_byte(8'h77);
    wait_done("timeout_reload");
    repeat (2) tick();
    checks++;
    if (tb_ram[0] !== 8'h77 || n_done != 1 || n_writes != 1) begin
      errors++;
      $display("FAIL timeout_reload: ram0=%h done=%0d writes=%0d, required 77 1 1", tb_ram[0], n_done, n_writes);
    end
  endtask

  task automatic test_abort();
    bit was_ready = 1'b0;
    clear_mon();
    do_start(5'd4);
    send_byte(8'h11);
    send_byte(8'h22);
    for (int k = 0; k < 20; k++) begin
      if (byte_ready) begin
        was_ready = 1'b1;
        break;
      end
      tick();
    end
    abort = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h33;
    #1;
    checks++;
    if (was_ready !== 1'b1 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready: reached_wait=%b byte_ready=%b under abort, required 1 0", was_ready, byte_ready);
    end
    tick();
    abort = 1'b0;
    byte_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b cpu_hold=%b, required 0 0", busy, cpu_hold);
    end
    repeat (8) tick();
    checks++;
    if (n_writes != 2 || n_done != 0 || error !== 1'b0) begin
      errors++;
      $display("FAIL abort_effects: writes=%0d done=%0d error=%b, required 2 0 0", n_writes, n_done, error);
    end

    do_start(5'd2);
    tick();
    start = 1'b1;
    prog_len = 5'd0;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_start: busy=%b done=%b byte_ready=%b, required 1 0 1", busy, done, byte_ready);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || n_done != 0) begin
      errors++;
      $display("FAIL busy_start_abort: busy=%b done_count=%0d, required 0 0", busy, n_done);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    do_start(5'd2);
    send_byte(8'h5A);
    checks++;
    if (mar_load !== 1'b1 || mar_addr !== 4'd0) begin
      errors++;
      $display("FAIL mid_mar: mar_load=%b mar_addr=%0d, required 1 0", mar_load, mar_addr);
    end
    tick();
    checks++;
    if (ram_write !== 1'b1 || ram_data !== 8'h5A) begin
      errors++;
      $display("FAIL mid_write: ram_write=%b ram_data=%h, required 1 5a", ram_write, ram_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready, mar_load, mar_addr, ram_write, ram_data, cpu_hold, busy, done, error} !== 19'd0) begin
      errors++;
      $display("FAIL mid_reset: got %b, required all zero",
               {byte_ready, mar_load, mar_addr, ram_write, ram_data, cpu_hold, busy, done, error});
    end
    tick();
    rst_n = 1'b1;
    tick();
    clear_mon();
    do_start(5'd1);
    send_byte(8'h99);
    wait_done("mid_reload");
    repeat (2) tick();
    checks++;
    if (tb_ram[0] !== 8'h99 || n_done != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reload: ram0=%h done=%0d busy=%b, required 99 1 0", tb_ram[0], n_done, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    byte_valid = 1'b0;
    prog_len = 5'd0;
    byte_data = 8'h00;
    test_reset();
    test_basic();
    test_timing();
    test_long_and_empty();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
